// File: rtl/bram_initiator_pkg.sv
// Shared types and sizing helpers for the block-RAM port initiator.
// Response entry layout, MSB to LSB: {data, write, error}.
package bram_initiator_pkg;

    localparam int unsigned RESP_DATA_W = 32;

    // Response entry at the default 32-bit word width.
    typedef struct packed {
        logic [RESP_DATA_W-1:0] data;
        logic                   write;
        logic                   error;
    } resp_entry_t;

    localparam int unsigned RESP_ENTRY_W = $bits(resp_entry_t);

    // Packed entry width for an arbitrary data width.
    function automatic int unsigned entry_width(input int unsigned data_w);
        return data_w + 2;
    endfunction

    // Pointer width for a power-of-two FIFO depth.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bram_resp_fifo.sv
// Synchronous response FIFO with occupancy count.
// Ports: clock, reset (async, active-high), push/push_data, pop,
//        head_data (current head entry), count (entries held).
// Pops on an empty FIFO are ignored; the caller prevents overflow.
module bram_resp_fifo
    import bram_initiator_pkg::*;
#(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              head_data,
    output logic [ptr_width(DEPTH):0]     count
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    assign do_pop    = pop & (count != '0);
    assign head_data = storage[rd_ptr];

    // Entry storage needs no reset: the head is only observed when count != 0.
    always_ff @(posedge clock) begin
        if (push) begin
            storage[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bram_port_initiator.sv
// Request-side driver for one port of a simple dual-port block RAM
// (1-cycle registered read, write-through readback, no backpressure).
// Ports:
//   clock, reset                 : clock, async active-high reset
//   req_valid/req_ready/req_*    : request stream (write flag, address, data)
//   ram_writeEnable/address/writeData, ram_readData : raw RAM port
//   resp_valid/resp_ready/resp_* : response stream (data, write flag, error)
// Optional: define BRAM_INITIATOR_STATS_EN to add the saturating
//   stat_reads / stat_writes / stat_stalls counters.
module bram_port_initiator
    import bram_initiator_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned INDEX_BITS    = 8,
    parameter int unsigned RESP_DEPTH    = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDRESS_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0]    req_data,
    output logic                     ram_writeEnable,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0]    ram_writeData,
    input  logic [DATA_WIDTH-1:0]    ram_readData,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_data,
    output logic                     resp_write,
    output logic                     resp_error
`ifdef BRAM_INITIATOR_STATS_EN
    ,
    output logic [31:0]              stat_reads,
    output logic [31:0]              stat_writes,
    output logic [31:0]              stat_stalls
`endif
);

    localparam int unsigned PTR_W   = ptr_width(RESP_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned OCC_W   = CNT_W + 1;
    localparam int unsigned ENTRY_W = entry_width(DATA_WIDTH);

    logic                  accept;
    logic                  oor;
    logic                  inflight;
    logic                  infl_write;
    logic                  infl_oor;
    logic [DATA_WIDTH-1:0] infl_data;
    logic [CNT_W-1:0]      fifo_count;
    logic [OCC_W-1:0]      occupancy;
    logic [ENTRY_W-1:0]    push_entry;
    logic [ENTRY_W-1:0]    head_entry;
    logic                  pop;

    // Address range check: any set bit above the RAM index is out of range.
    if (INDEX_BITS >= ADDRESS_WIDTH) begin : g_no_range
        assign oor = 1'b0;
    end else begin : g_range
        assign oor = |req_address[ADDRESS_WIDTH-1:INDEX_BITS];
    end

    // Reserve a FIFO slot for every accepted request, including the one in flight.
    always_comb begin
        occupancy = OCC_W'(fifo_count) + OCC_W'(inflight);
        req_ready = ~reset & (occupancy < OCC_W'(RESP_DEPTH));
        accept    = req_valid & req_ready;
    end

    // Combinational RAM drive; out-of-range writes are suppressed.
    assign ram_address     = req_address;
    assign ram_writeData   = req_data;
    assign ram_writeEnable = accept & req_write & ~oor;

    // Issue stage: remembers what the RAM will answer next cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight   <= 1'b0;
            infl_write <= 1'b0;
            infl_oor   <= 1'b0;
            infl_data  <= '0;
        end else begin
            inflight <= accept;
            if (accept) begin
                infl_write <= req_write;
                infl_oor   <= oor;
                infl_data  <= req_data;
            end
        end
    end

    // Capture: writes echo the issued data, which equals the RAM's write-through readback.
    always_comb begin
        push_entry = '0;
        if (!infl_oor) begin
            push_entry[ENTRY_W-1:2] = infl_write ? infl_data : ram_readData;
        end
        push_entry[1] = infl_write;
        push_entry[0] = infl_oor;
    end

    assign pop = resp_valid & resp_ready;

    bram_resp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (inflight),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .count     (fifo_count)
    );

    // Response outputs are forced to zero whenever the FIFO is empty.
    always_comb begin
        resp_valid = (fifo_count != '0);
        resp_data  = resp_valid ? head_entry[ENTRY_W-1:2] : '0;
        resp_write = resp_valid & head_entry[1];
        resp_error = resp_valid & head_entry[0];
    end

`ifdef BRAM_INITIATOR_STATS_EN
    // Saturating activity counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_reads  <= '0;
            stat_writes <= '0;
            stat_stalls <= '0;
        end else begin
            if (accept && !req_write && (stat_reads != '1)) begin
                stat_reads <= stat_reads + 32'(1);
            end
            if (accept && req_write && (stat_writes != '1)) begin
                stat_writes <= stat_writes + 32'(1);
            end
            if (req_valid && !req_ready && (stat_stalls != '1)) begin
                stat_stalls <= stat_stalls + 32'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_bram_port_initiator.sv
// Directed self-checking bench for bram_port_initiator with a behavioural
// 256-word block-RAM model (registered read, write-through readback).
module tb_bram_port_initiator;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_address;
    logic [31:0] req_data;
    logic        ram_writeEnable;
    logic [31:0] ram_address;
    logic [31:0] ram_writeData;
    logic [31:0] ram_readData;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_write;
    logic        resp_error;
`ifdef BRAM_INITIATOR_STATS_EN
    logic [31:0] stat_reads;
    logic [31:0] stat_writes;
    logic [31:0] stat_stalls;
`endif

    logic        preload;
    logic [31:0] mem [256];

    int vectors;
    int miscompares;

    bram_port_initiator dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_address     (req_address),
        .req_data        (req_data),
        .ram_writeEnable (ram_writeEnable),
        .ram_address     (ram_address),
        .ram_writeData   (ram_writeData),
        .ram_readData    (ram_readData),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data),
        .resp_write      (resp_write),
        .resp_error      (resp_error)
`ifdef BRAM_INITIATOR_STATS_EN
        ,
        .stat_reads      (stat_reads),
        .stat_writes     (stat_writes),
        .stat_stalls     (stat_stalls)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM model: preload value = address for 0..15, else zero.
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= (i < 16) ? 32'(i) : 32'h0;
            end
            ram_readData <= 32'h0;
        end else begin
            if (ram_writeEnable) begin
                mem[ram_address[7:0]] <= ram_writeData;
            end
            ram_readData <= ram_writeEnable ? ram_writeData : mem[ram_address[7:0]];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
        req_valid   = v;
        req_write   = w;
        req_address = a;
        req_data    = d;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        preload     = 1'b1;
        reset       = 1'b1;
        resp_ready  = 1'b1;
        drive(1'b1, 1'b1, 32'h0, 32'h55);

        // Reset state, with a write request presented to prove it is blocked.
        tick();
        tick();
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'h0);
        check_eq("rst_ram_we", 32'(ram_writeEnable), 32'h0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'h0);
        check_eq("rst_resp_data", resp_data, 32'h0);
        check_eq("rst_resp_write", 32'(resp_write), 32'h0);
        check_eq("rst_resp_error", 32'(resp_error), 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        preload = 1'b0;
        reset   = 1'b0;

        // Write 0xAB to 0x10.
        tick();
        drive(1'b1, 1'b1, 32'h10, 32'hAB);
        #1;
        check_eq("wr_req_ready", 32'(req_ready), 32'h1);
        check_eq("wr_ram_we", 32'(ram_writeEnable), 32'h1);
        check_eq("wr_ram_addr", ram_address, 32'h10);
        check_eq("wr_ram_wdata", ram_writeData, 32'hAB);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_eq("wr_resp_not_yet", 32'(resp_valid), 32'h0);
        tick();
        check_eq("wr_resp_valid", 32'(resp_valid), 32'h1);
        check_eq("wr_resp_data", resp_data, 32'hAB);
        check_eq("wr_resp_write", 32'(resp_write), 32'h1);
        check_eq("wr_resp_error", 32'(resp_error), 32'h0);
        tick();
        check_eq("wr_resp_popped", 32'(resp_valid), 32'h0);

        // Read back 0x10.
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        check_eq("rd_ram_we", 32'(ram_writeEnable), 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check_eq("rd_resp_valid", 32'(resp_valid), 32'h1);
        check_eq("rd_resp_data", resp_data, 32'hAB);
        check_eq("rd_resp_write", 32'(resp_write), 32'h0);
        tick();

        // 16 back-to-back reads, response i-2 visible while request i is presented.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 32'(i), 32'h0);
            #1;
            check_eq($sformatf("b2b_ready_%0d", i), 32'(req_ready), 32'h1);
            if (i >= 2) begin
                check_eq($sformatf("b2b_valid_%0d", i), 32'(resp_valid), 32'h1);
                check_eq($sformatf("b2b_data_%0d", i), resp_data, 32'(i - 2));
            end else begin
                check_eq($sformatf("b2b_valid_%0d", i), 32'(resp_valid), 32'h0);
            end
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_eq("b2b_data_14", resp_data, 32'd14);
        tick();
        check_eq("b2b_data_15", resp_data, 32'd15);
        tick();
        check_eq("b2b_drained", 32'(resp_valid), 32'h0);

        // Stall: resp_ready low, six reads pending, only four accepted.
        resp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 32'(k), 32'h0);
            #1;
            check_eq($sformatf("stall_acc_%0d", k), 32'(req_ready), 32'h1);
            tick();
        end
        drive(1'b1, 1'b0, 32'h4, 32'h0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq($sformatf("stall_block_%0d", k), 32'(req_ready), 32'h0);
            check_eq($sformatf("stall_hold_valid_%0d", k), 32'(resp_valid), 32'h1);
            check_eq($sformatf("stall_hold_data_%0d", k), resp_data, 32'h0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        check_eq("drain_a_ready", 32'(req_ready), 32'h0);
        check_eq("drain_a_data", resp_data, 32'h0);
        tick();
        check_eq("drain_b_ready", 32'(req_ready), 32'h1);
        check_eq("drain_b_data", resp_data, 32'h1);
        tick();
        drive(1'b1, 1'b0, 32'h5, 32'h0);
        #1;
        check_eq("drain_c_ready", 32'(req_ready), 32'h1);
        check_eq("drain_c_data", resp_data, 32'h2);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_eq("drain_d_data", resp_data, 32'h3);
        tick();
        check_eq("drain_e_data", resp_data, 32'h4);
        tick();
        check_eq("drain_f_data", resp_data, 32'h5);
        tick();
        check_eq("drain_empty", 32'(resp_valid), 32'h0);

        // Out-of-range write to 0x100 must not touch RAM word 0.
        drive(1'b1, 1'b1, 32'h100, 32'hDEAD);
        #1;
        check_eq("oor_req_ready", 32'(req_ready), 32'h1);
        check_eq("oor_ram_we", 32'(ram_writeEnable), 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check_eq("oor_resp_valid", 32'(resp_valid), 32'h1);
        check_eq("oor_resp_error", 32'(resp_error), 32'h1);
        check_eq("oor_resp_data", resp_data, 32'h0);
        check_eq("oor_resp_write", 32'(resp_write), 32'h1);
        tick();
        drive(1'b1, 1'b0, 32'h0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check_eq("oor_read0_valid", 32'(resp_valid), 32'h1);
        check_eq("oor_read0_data", resp_data, 32'h0);
        check_eq("oor_read0_error", 32'(resp_error), 32'h0);
        tick();

        // Two responses queued and one in flight, then reset.
        resp_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 1'b0, 32'(k), 32'h0);
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_eq("pre_rst_valid", 32'(resp_valid), 32'h1);
        check_eq("pre_rst_data", resp_data, 32'h1);
`ifdef BRAM_INITIATOR_STATS_EN
        check_eq("stat_reads", stat_reads, 32'd27);
        check_eq("stat_writes", stat_writes, 32'd2);
        check_eq("stat_stalls", stat_stalls, 32'd4);
`endif
        reset = 1'b1;
        #1;
        check_eq("mid_rst_valid", 32'(resp_valid), 32'h0);
        check_eq("mid_rst_data", resp_data, 32'h0);
        check_eq("mid_rst_ready", 32'(req_ready), 32'h0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_eq("post_rst_ready", 32'(req_ready), 32'h1);
        check_eq("post_rst_valid", 32'(resp_valid), 32'h0);
        tick();
        check_eq("post_rst_no_stray", 32'(resp_valid), 32'h0);
`ifdef BRAM_INITIATOR_STATS_EN
        check_eq("stat_reads_clr", stat_reads, 32'h0);
        check_eq("stat_writes_clr", stat_writes, 32'h0);
        check_eq("stat_stalls_clr", stat_stalls, 32'h0);
`endif
        resp_ready = 1'b1;
        drive(1'b1, 1'b0, 32'h5, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check_eq("post_rst_rd_valid", 32'(resp_valid), 32'h1);
        check_eq("post_rst_rd_data", resp_data, 32'h5);
        check_eq("post_rst_rd_write", 32'(resp_write), 32'h0);
        tick();
        check_eq("post_rst_rd_popped", 32'(resp_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bram_port_initiator.md
Name: bram_port_initiator

Overview:
- Request-side driver for one port of the simple dual-port block RAM, which has 1-cycle registered read latency, write-through readback and no backpressure.
- Converts a valid/ready request stream from a cache, DMA or core into the RAM's raw port signals (writeEnable/address/writeData).
- Captures the RAM's registered readData one cycle later into a response FIFO, then returns it on a valid/ready response stream.
- Two instances, one per RAM port, give two independent masters full-throughput access.

Parameters:
- DATA_WIDTH, 32, RAM word width.
- ADDRESS_WIDTH, 32, request/RAM address width.
- INDEX_BITS, 8, log2 of RAM depth; upper address bits must be zero.
- RESP_DEPTH, 4, response FIFO entries (power of 2, >= 2).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_address  in  ADDRESS_WIDTH  word address.
- req_data  in  DATA_WIDTH  write data.
- ram_writeEnable  out  1  to RAM port writeEnable.
- ram_address  out  ADDRESS_WIDTH  to RAM port address.
- ram_writeData  out  DATA_WIDTH  to RAM port writeData.
- ram_readData  in  DATA_WIDTH  from RAM port readData (registered in RAM).
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_data  out  DATA_WIDTH  read data, or echoed write data for writes.
- resp_write  out  1  response belongs to a write.
- resp_error  out  1  address out of range.

Behaviour:
- Accept rule: accept = req_valid & req_ready.
- req_ready = ~reset & ((fifo_count + inflight) < RESP_DEPTH). Registered state only; no combinational path from resp_ready.
- Range check: oor = |req_address[ADDRESS_WIDTH-1:INDEX_BITS]. If INDEX_BITS == ADDRESS_WIDTH, oor = 0.
- RAM drive (combinational):
  - ram_address = req_address.
  - ram_writeData = req_data.
  - ram_writeEnable = accept & req_write & ~oor. An out-of-range write never reaches the RAM.
- Issue stage registers, set on the accepting edge: inflight <= accept, infl_write <= req_write, infl_oor <= oor, infl_data <= req_data.
- Capture: in the cycle after an accept (inflight = 1), push one FIFO entry:
  - data = infl_oor ? 0 : ram_readData;
  - write = infl_write;
  - error = infl_oor.
  - For in-range writes the RAM's write-through makes ram_readData equal the written data.
- Latency: request accepted at edge N -> response pushed at edge N+1 -> resp_valid high in the cycle after edge N+1 (minimum 1-cycle accept-to-response). Sustained throughput is 1 request per cycle while resp_ready = 1.
- Response FIFO:
  - resp_valid = (fifo_count != 0); resp_* are driven from the head entry.
  - Pop on resp_valid & resp_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo RESP_DEPTH.
  - Overflow cannot occur, by the req_ready rule.
- Ordering: responses return strictly in request order.
- Stall: with resp_ready = 0, at most RESP_DEPTH requests are accepted, then req_ready = 0 until a pop. resp_* remain stable while resp_valid & ~resp_ready.
- Reset (asynchronous, any time, including mid-transaction):
  - inflight = 0, fifo_count = 0, pointers = 0.
  - resp_valid = 0, resp_data = 0, resp_write = 0, resp_error = 0, req_ready = 0, ram_writeEnable = 0.
  - An in-flight response is dropped. A write already issued to the RAM before reset stands.
- No FSM beyond issue/capture. States are implied by {inflight, fifo_count}: IDLE (0,0), BUSY, FULL (sum == RESP_DEPTH).

Optional Feature:
- Macro: BRAM_INITIATOR_STATS_EN.
- Defined:
  - Adds outputs stat_reads, stat_writes, stat_stalls, each 32 bits.
  - stat_reads counts accepted reads; stat_writes counts accepted writes.
  - stat_stalls counts cycles with req_valid & ~req_ready.
  - All saturate at 0xFFFFFFFF and clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package bram_initiator_pkg holds:
  - a response-entry struct/typedef {data, write, error} and its packed width;
  - a function computing the pointer width from RESP_DEPTH.
- Sub-module bram_resp_fifo: synchronous FIFO with count output, push/pop, async reset, depth RESP_DEPTH.

Test Plan:
- Write 0x000000AB to address 0x10 with resp_ready = 1 -> ram_writeEnable high on the accept cycle; one cycle later resp_valid = 1, resp_data = 0xAB, resp_write = 1, resp_error = 0.
- Read 0x10 after that write -> resp_data = 0xAB, resp_write = 0, latency 1 cycle.
- 16 back-to-back reads of addresses 0..15, preloaded with value = address, resp_ready = 1 -> req_ready never drops; responses 0..15 in order, one per cycle.
- resp_ready = 0 with 6 reads pending -> exactly 4 accepted, req_ready = 0 thereafter. Raising resp_ready drains 4 in order, then the remaining 2 are accepted.
- Write to address 0x100 (INDEX_BITS = 8) -> ram_writeEnable stays 0; response has resp_error = 1, resp_data = 0. A following read of 0x00 is unchanged.
- Assert reset while 2 responses are queued and 1 is in flight -> resp_valid drops immediately; after release the FIFO is empty and the next read of 0x05 returns the correct data. With STATS_EN, counters read 0 after reset.
